// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat: per-key debounce with press/release pulses, long-press flag and auto-repeat.
// A shared millisecond tick paces every key's FSM; all outputs are registered.
module key_debounce_repeat #(
    parameter int N_KEYS          = 5,
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic              CLK_50,
    input  logic              CR,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_repeat,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              any_event
);
    localparam int DIV    = CLK_HZ / 1000;
    localparam int DW     = $clog2(DIV);
    localparam int MAX_A  = DEBOUNCE_MS > REPEAT_DELAY_MS ? DEBOUNCE_MS : REPEAT_DELAY_MS;
    localparam int MAX_MS = MAX_A > REPEAT_RATE_MS ? MAX_A : REPEAT_RATE_MS;
    localparam int CW     = $clog2(MAX_MS + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [CW-1:0] DEB     = CW'(DEBOUNCE_MS);
    localparam logic [CW-1:0] DLY     = CW'(REPEAT_DELAY_MS);
    localparam logic [CW-1:0] RATE    = CW'(REPEAT_RATE_MS);

    typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE} state_t;

    logic [N_KEYS-1:0] sync_a, sync_b;
    logic [DW-1:0]     div;
    logic              tick;
    state_t            st  [N_KEYS];
    logic [CW-1:0]     cnt [N_KEYS];
    logic [CW-1:0]     inc [N_KEYS];

    assign tick = div == DIV_MAX;

    always_comb
        for (int i = 0; i < N_KEYS; i++)
            inc[i] = cnt[i] + CW'(1);

    always_ff @(posedge CLK_50) begin
        if (CR) begin
            sync_a <= '0;
            sync_b <= '0;
            div    <= '0;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
            div    <= tick ? '0 : div + DW'(1);
        end
    end

    // Pulses default low every cycle; any_event is raised alongside any press or repeat.
    always_ff @(posedge CLK_50) begin
        key_press   <= '0;
        key_repeat  <= '0;
        key_release <= '0;
        any_event   <= 1'b0;
        if (CR) begin
            key_level <= '0;
            key_long  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                case (st[i])
                    IDLE:
                        if (sync_b[i]) begin
                            st[i]  <= DEB_PRESS;
                            cnt[i] <= '0;
                        end
                    DEB_PRESS:
                        if (!sync_b[i]) begin
                            st[i] <= IDLE;
                        end else if (tick) begin
                            if (inc[i] == DEB) begin
                                st[i]        <= HELD;
                                cnt[i]       <= '0;
                                key_press[i] <= 1'b1;
                                key_level[i] <= 1'b1;
                                any_event    <= 1'b1;
                            end else begin
                                cnt[i] <= inc[i];
                            end
                        end
                    HELD:
                        if (!sync_b[i]) begin
                            st[i]  <= DEB_RELEASE;
                            cnt[i] <= '0;
                        end else if (tick && cnt[i] != DLY) begin
                            cnt[i] <= inc[i];
                            if (inc[i] == DLY) begin
                                key_long[i] <= 1'b1;
                                if (repeat_en[i]) begin
                                    st[i]         <= REPEAT;
                                    cnt[i]        <= '0;
                                    key_repeat[i] <= 1'b1;
                                    any_event     <= 1'b1;
                                end
                            end
                        end
                    REPEAT:
                        if (!sync_b[i]) begin
                            st[i]  <= DEB_RELEASE;
                            cnt[i] <= '0;
                        end else if (tick) begin
                            cnt[i] <= inc[i] == RATE ? '0 : inc[i];
                            if (inc[i] == RATE && repeat_en[i]) begin
                                key_repeat[i] <= 1'b1;
                                any_event     <= 1'b1;
                            end
                        end
                    DEB_RELEASE:
                        if (sync_b[i]) begin
                            st[i]  <= key_long[i] ? REPEAT : HELD;
                            cnt[i] <= '0;
                        end else if (tick) begin
                            if (inc[i] == DEB) begin
                                st[i]          <= IDLE;
                                cnt[i]         <= '0;
                                key_release[i] <= 1'b1;
                                key_level[i]   <= 1'b0;
                                key_long[i]    <= 1'b0;
                            end else begin
                                cnt[i] <= inc[i];
                            end
                        end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb_key_debounce_repeat: directed and randomized scenarios checked against a tick-counting reference model.
module tb_key_debounce_repeat;
    localparam int N = 5, HZ = 4000, DEB = 3, RD = 10, RR = 4, DIV = HZ / 1000;

    logic         CLK_50 = 1'b0;
    logic         CR = 1'b1;
    logic [N-1:0] key_raw = '0, repeat_en = '0;
    logic [N-1:0] key_level, key_press, key_repeat, key_release, key_long;
    logic         any_event;

    key_debounce_repeat #(
        .N_KEYS(N), .CLK_HZ(HZ), .DEBOUNCE_MS(DEB), .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR)
    ) dut (
        .CLK_50(CLK_50), .CR(CR), .key_raw(key_raw), .repeat_en(repeat_en),
        .key_level(key_level), .key_press(key_press), .key_repeat(key_repeat),
        .key_release(key_release), .key_long(key_long), .any_event(any_event)
    );

    always #5 CLK_50 = ~CLK_50;

    wire  [5*N:0] obs = {key_level, key_press, key_repeat, key_release, key_long, any_event};
    logic [5*N:0] expv = '0;
    int tests = 0, failed = 0, gcyc = 0;
    int n_prs, n_rep, n_rel;

    // Reference: debounce counts ticks of disagreement between the synced key and the accepted
    // level; hold time counts ticks since acceptance (or since a rejected release glitch).
    logic [N-1:0] h1 = '0, h2 = '0, lvl = '0, lng = '0, strk = '0, rmode = '0;
    int cyc = 0;
    int dt [N], ht [N], base [N];

    task automatic model_step();
        logic [N-1:0] s, p, r, l;
        bit t;
        if (CR) begin
            h1 = '0; h2 = '0; lvl = '0; lng = '0; strk = '0; rmode = '0; cyc = 0; expv = '0;
            return;
        end
        s = h2; h2 = h1; h1 = key_raw;
        t = (cyc % DIV) == DIV - 1;
        cyc++;
        p = '0; r = '0; l = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] != lvl[i]) begin
                if (!strk[i]) begin
                    strk[i] = 1'b1;
                    dt[i] = 0;
                end else if (t) begin
                    dt[i]++;
                    if (dt[i] == DEB) begin
                        strk[i] = 1'b0;
                        if (lvl[i]) begin
                            l[i] = 1'b1; lvl[i] = 1'b0; lng[i] = 1'b0;
                        end else begin
                            p[i] = 1'b1; lvl[i] = 1'b1; ht[i] = 0; rmode[i] = 1'b0;
                        end
                    end
                end
            end else begin
                if (strk[i] && lvl[i]) begin
                    ht[i] = 0; rmode[i] = lng[i]; base[i] = 0;
                end else if (lvl[i] && t) begin
                    ht[i]++;
                    if (!rmode[i] && ht[i] == RD) begin
                        lng[i] = 1'b1;
                        if (repeat_en[i]) begin
                            rmode[i] = 1'b1; base[i] = RD; r[i] = 1'b1;
                        end
                    end else if (rmode[i] && (ht[i] - base[i]) % RR == 0) begin
                        r[i] = repeat_en[i];
                    end
                end
                strk[i] = 1'b0;
            end
        end
        expv = {lvl, p, r, l, lng, |(p | r)};
    endtask

    task automatic cycle();
        @(posedge CLK_50);
        model_step();
        @(negedge CLK_50);
        gcyc++;
        n_prs += $countones(key_press);
        n_rep += $countones(key_repeat);
        n_rel += $countones(key_release);
    endtask

    task automatic test_reset();
        CR = 1'b1; key_raw = 5'b10101; repeat_en = '1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            tests++;
            if (obs !== '0) begin failed++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        end
        CR = 1'b0; key_raw = '0;
        n_prs = 0; n_rep = 0; n_rel = 0;
    endtask

    task automatic test_clean_press();
        int tp = -1, tr1 = -1, tr2 = -1;
        n_prs = 0; n_rep = 0; n_rel = 0; repeat_en = 5'b00001;
        for (int k = 0; k < 120; k++) begin
            key_raw = k < 80 ? 5'b00001 : 5'b00000;
            cycle();
            tests++;
            if (obs !== expv) begin failed++; $display("FAIL clean_model cyc=%0d got=%h exp=%h", gcyc, obs, expv); end
            if (key_press[0]) tp = k;
            if (key_repeat[0]) begin
                if (tr1 < 0) begin
                    tr1 = k;
                    tests++;
                    if (key_long[0] !== 1'b1) begin failed++; $display("FAIL clean_long_at_repeat got=%b exp=1", key_long[0]); end
                end else if (tr2 < 0) tr2 = k;
            end
        end
        tests++;
        if (n_prs !== 1) begin failed++; $display("FAIL clean_press_count got=%0d exp=1", n_prs); end
        tests++;
        if (n_rep !== 2) begin failed++; $display("FAIL clean_repeat_count got=%0d exp=2", n_rep); end
        tests++;
        if (tp < 11 || tp > 14) begin failed++; $display("FAIL clean_press_latency got=%0d exp=11..14", tp); end
        tests++;
        if (tr1 - tp !== 40) begin failed++; $display("FAIL clean_first_repeat got=%0d exp=40", tr1 - tp); end
        tests++;
        if (tr2 - tr1 !== 16) begin failed++; $display("FAIL clean_repeat_period got=%0d exp=16", tr2 - tr1); end
        tests++;
        if (n_rel !== 1) begin failed++; $display("FAIL clean_release_count got=%0d exp=1", n_rel); end
    endtask

    task automatic test_bounce();
        logic seen = 1'b0;
        n_prs = 0; repeat_en = '1;
        for (int k = 0; k < 60; k++) begin
            key_raw = (k < 32 && k % 2 == 0) ? 5'b00010 : 5'b00000;
            cycle();
            seen |= key_level[1];
            tests++;
            if (obs !== expv) begin failed++; $display("FAIL bounce_model cyc=%0d got=%h exp=%h", gcyc, obs, expv); end
        end
        tests++;
        if (n_prs !== 0) begin failed++; $display("FAIL bounce_press_count got=%0d exp=0", n_prs); end
        tests++;
        if (seen !== 1'b0) begin failed++; $display("FAIL bounce_level got=%b exp=0", seen); end
    endtask

    task automatic test_glitch();
        int win_rep = 0, win_rel = 0;
        logic dropped = 1'b0;
        n_rel = 0; repeat_en = 5'b00100;
        for (int k = 0; k < 150; k++) begin
            key_raw = (k < 70 || (k >= 74 && k < 120)) ? 5'b00100 : 5'b00000;
            cycle();
            tests++;
            if (obs !== expv) begin failed++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", gcyc, obs, expv); end
            if (k >= 20 && k < 120) dropped |= ~key_level[2];
            if (k < 120) win_rel += key_release[2];
            if (k >= 74 && k < 120) win_rep += key_repeat[2];
        end
        tests++;
        if (win_rel !== 0) begin failed++; $display("FAIL glitch_release got=%0d exp=0", win_rel); end
        tests++;
        if (dropped !== 1'b0) begin failed++; $display("FAIL glitch_level got=%b exp=0", dropped); end
        tests++;
        if (win_rep !== 2) begin failed++; $display("FAIL glitch_repeat_resumed got=%0d exp=2", win_rep); end
        tests++;
        if (n_rel !== 1) begin failed++; $display("FAIL glitch_final_release got=%0d exp=1", n_rel); end
    endtask

    task automatic test_no_repeat();
        int tp = -1, tl = -1, trl = -1;
        n_prs = 0; n_rep = 0; n_rel = 0; repeat_en = '0;
        for (int k = 0; k < 120; k++) begin
            key_raw = k < 80 ? 5'b01000 : 5'b00000;
            cycle();
            tests++;
            if (obs !== expv) begin failed++; $display("FAIL norep_model cyc=%0d got=%h exp=%h", gcyc, obs, expv); end
            if (key_press[3]) tp = k;
            if (key_long[3] && tl < 0) tl = k;
            if (key_release[3]) trl = k;
        end
        tests++;
        if (n_prs !== 1 || n_rep !== 0 || n_rel !== 1) begin
            failed++; $display("FAIL norep_counts got=%0d/%0d/%0d exp=1/0/1", n_prs, n_rep, n_rel);
        end
        tests++;
        if (tl - tp !== 40) begin failed++; $display("FAIL norep_long_delay got=%0d exp=40", tl - tp); end
        tests++;
        if (trl - 80 < 11 || trl - 80 > 14) begin failed++; $display("FAIL norep_release_latency got=%0d exp=11..14", trl - 80); end
    endtask

    task automatic test_simultaneous();
        int both = 0;
        n_prs = 0; repeat_en = '1;
        for (int k = 0; k < 80; k++) begin
            key_raw = k < 40 ? 5'b10001 : 5'b00000;
            cycle();
            tests++;
            if (obs !== expv) begin failed++; $display("FAIL simul_model cyc=%0d got=%h exp=%h", gcyc, obs, expv); end
            if (key_press == 5'b10001 && any_event) both++;
        end
        tests++;
        if (both !== 1) begin failed++; $display("FAIL simul_press_cycle got=%0d exp=1", both); end
        tests++;
        if (n_prs !== 2) begin failed++; $display("FAIL simul_press_count got=%0d exp=2", n_prs); end
    endtask

    task automatic test_reset_mid();
        int tp = -1, rel = 0;
        n_prs = 0; repeat_en = 5'b00001;
        for (int k = 0; k < 140; k++) begin
            key_raw = k < 110 ? 5'b00001 : 5'b00000;
            CR = k == 64;
            cycle();
            tests++;
            if (obs !== expv) begin failed++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", gcyc, obs, expv); end
            if (k == 63) begin
                tests++;
                if (key_long[0] !== 1'b1) begin failed++; $display("FAIL rstmid_in_repeat got=%b exp=1", key_long[0]); end
            end
            if (k == 64) begin
                tests++;
                if (obs !== '0) begin failed++; $display("FAIL rstmid_cleared got=%h exp=0", obs); end
            end
            if (k > 64 && key_press[0] && tp < 0) tp = k;
            if (k < 110) rel += key_release[0];
        end
        CR = 1'b0;
        tests++;
        if (rel !== 0) begin failed++; $display("FAIL rstmid_release got=%0d exp=0", rel); end
        tests++;
        if (tp - 65 < 11 || tp - 65 > 14) begin failed++; $display("FAIL rstmid_repress got=%0d exp=11..14", tp - 65); end
    endtask

    task automatic test_random();
        logic [N-1:0] held = '0, bounce, pl, prev = '0;
        int j;
        for (int k = 0; k < 4000; k++) begin
            bounce = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 79) == 0) held[i] = ~held[i];
                bounce[i] = $urandom_range(0, 19) == 0;
            end
            key_raw = held ^ bounce;
            if ($urandom_range(0, 299) == 0) begin
                j = $urandom_range(0, N - 1);
                repeat_en[j] = ~repeat_en[j];
            end
            CR = $urandom_range(0, 1499) == 0;
            cycle();
            tests++;
            if (obs !== expv) begin failed++; $display("FAIL random_model cyc=%0d got=%h exp=%h", gcyc, obs, expv); end
            pl = key_press | key_repeat | key_release;
            tests++;
            if ((pl & prev) !== '0 || ((key_press & key_repeat) | (key_press & key_release) | (key_repeat & key_release)) !== '0) begin
                failed++; $display("FAIL random_pulse_rules cyc=%0d got=%b prev=%b exp=exclusive", gcyc, pl, prev);
            end
            prev = pl;
        end
        CR = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_no_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
